// File: rtl/value_range_pkg.sv
// value_range_pkg
// Shared definitions for the value range checker.
//   range_desc_t : describes an allowed interval `from [lo:hi] exclude [excl_lo:excl_hi)`.
//   in_range()   : evaluates one sample against a descriptor. The sample must be
//                  sign-extended to DESC_W bits by the caller, so the same function
//                  serves any sample width up to DESC_W.
package value_range_pkg;

    localparam int DESC_W = 32;

    typedef struct packed {
        int   lo;
        int   hi;
        logic lo_incl;
        logic hi_incl;
        logic lo_inf;
        logic hi_inf;
        logic excl_en;
        int   excl_lo;
        int   excl_hi;
    } range_desc_t;

    // The exclusion window is half-open [excl_lo, excl_hi). If excl_lo >= excl_hi,
    // the window is empty. If lo > hi, no sample passes.
    function automatic logic in_range(input logic signed [DESC_W-1:0] sample,
                                      input range_desc_t desc);
        logic lo_pass_s;
        logic hi_pass_s;
        logic excl_hit_s;
        if (desc.lo_inf) begin
            lo_pass_s = 1'b1;
        end else if (desc.lo_incl) begin
            lo_pass_s = (sample >= desc.lo);
        end else begin
            lo_pass_s = (sample > desc.lo);
        end
        if (desc.hi_inf) begin
            hi_pass_s = 1'b1;
        end else if (desc.hi_incl) begin
            hi_pass_s = (sample <= desc.hi);
        end else begin
            hi_pass_s = (sample < desc.hi);
        end
        excl_hit_s = desc.excl_en && (sample >= desc.excl_lo) && (sample < desc.excl_hi);
        return lo_pass_s && hi_pass_s && !excl_hit_s;
    endfunction

endpackage

// File: rtl/value_range_checker_range_compare.sv
// range_compare
// Purely combinational evaluator of ok(x) for one configured range.
// The bounds are checked at elaboration to confirm that they fit in WIDTH signed bits.
// When they fit, comparing sign-extended 32-bit values gives the same result as
// comparing at WIDTH bits.
// Ports:
//   x  : WIDTH-bit two's-complement sample
//   ok : 1 = sample inside the range and outside the exclusion window
module range_compare
    import value_range_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int LO      = -10,
    parameter int HI      = 10,
    parameter bit LO_INCL = 1'b1,
    parameter bit HI_INCL = 1'b1,
    parameter bit LO_INF  = 1'b0,
    parameter bit HI_INF  = 1'b0,
    parameter bit EXCL_EN = 1'b1,
    parameter int EXCL_LO = 1,
    parameter int EXCL_HI = 2
) (
    input  logic [WIDTH-1:0] x,
    output logic             ok
);

    localparam longint MIN_V = -(64'sd1 <<< (WIDTH - 1));
    localparam longint MAX_V = (64'sd1 <<< (WIDTH - 1)) - 64'sd1;

    if ((WIDTH < 2) || (WIDTH > DESC_W)) begin : g_bad_width
        $error("range_compare: WIDTH must lie in 2..32");
    end

    if ((longint'(LO) < MIN_V) || (longint'(LO) > MAX_V) ||
        (longint'(HI) < MIN_V) || (longint'(HI) > MAX_V) ||
        (longint'(EXCL_LO) < MIN_V) || (longint'(EXCL_LO) > MAX_V) ||
        (longint'(EXCL_HI) < MIN_V) || (longint'(EXCL_HI) > MAX_V)) begin : g_bad_bounds
        $error("range_compare: a bound is not representable in WIDTH signed bits");
    end

    localparam range_desc_t DESC = '{
        lo:      LO,
        hi:      HI,
        lo_incl: LO_INCL,
        hi_incl: HI_INCL,
        lo_inf:  LO_INF,
        hi_inf:  HI_INF,
        excl_en: EXCL_EN,
        excl_lo: EXCL_LO,
        excl_hi: EXCL_HI
    };

    logic signed [DESC_W-1:0] x_ext_s;

    assign x_ext_s = DESC_W'($signed(x));
    assign ok      = in_range(x_ext_s, DESC);

endmodule

// File: rtl/value_range_checker.sv
// value_range_checker
// Streaming range monitor. Every accepted sample is registered together with a
// pass/fail flag in a single-entry pipeline register. The monitor also keeps a
// saturating count of rejected samples and a sticky copy of the first rejected
// sample seen since reset or clear.
// Ports:
//   clk, rst_n                      : clock and synchronous active-low reset
//   in_valid/in_ready/in_data       : upstream handshake and sample
//   out_valid/out_ready             : downstream handshake
//   out_data/out_ok                 : registered sample and its pass flag
//   clear                           : one-cycle pulse that clears the count and the capture
//   viol_count                      : saturating count of rejected samples
//   first_bad_valid/first_bad       : sticky capture of the first rejected sample
module value_range_checker
    import value_range_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int LO      = -10,
    parameter int HI      = 10,
    parameter bit LO_INCL = 1'b1,
    parameter bit HI_INCL = 1'b1,
    parameter bit LO_INF  = 1'b0,
    parameter bit HI_INF  = 1'b0,
    parameter bit EXCL_EN = 1'b1,
    parameter int EXCL_LO = 1,
    parameter int EXCL_HI = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ok,
    input  logic             clear,
    output logic [CNT_W-1:0] viol_count,
    output logic             first_bad_valid,
    output logic [WIDTH-1:0] first_bad
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_ok_q, out_ok_d;
    logic [CNT_W-1:0] viol_count_q, viol_count_d;
    logic             first_bad_valid_q, first_bad_valid_d;
    logic [WIDTH-1:0] first_bad_q, first_bad_d;

    logic accept_s;
    logic ok_s;
    logic viol_s;

    range_compare #(
        .WIDTH   (WIDTH),
        .LO      (LO),
        .HI      (HI),
        .LO_INCL (LO_INCL),
        .HI_INCL (HI_INCL),
        .LO_INF  (LO_INF),
        .HI_INF  (HI_INF),
        .EXCL_EN (EXCL_EN),
        .EXCL_LO (EXCL_LO),
        .EXCL_HI (EXCL_HI)
    ) u_range_compare (
        .x  (in_data),
        .ok (ok_s)
    );

    // When the held sample leaves in the same cycle, the register can take a new
    // sample, so a continuous stream passes without bubbles.
    assign in_ready = !out_valid_q || out_ready;
    assign accept_s = in_valid && in_ready;
    assign viol_s   = accept_s && !ok_s;

    // Pipeline register next state: load on accept, drain on output handshake.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ok_d    = out_ok_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            out_ok_d    = ok_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Violation bookkeeping next state. A violation accepted in the same cycle as
    // clear counts as the first event after the clear.
    always_comb begin
        viol_count_d      = viol_count_q;
        first_bad_valid_d = first_bad_valid_q;
        first_bad_d       = first_bad_q;
        if (clear) begin
            if (viol_s) begin
                viol_count_d      = CNT_W'(1);
                first_bad_valid_d = 1'b1;
                first_bad_d       = in_data;
            end else begin
                viol_count_d      = {CNT_W{1'b0}};
                first_bad_valid_d = 1'b0;
            end
        end else if (viol_s) begin
            if (viol_count_q != CNT_MAX) begin
                viol_count_d = viol_count_q + CNT_W'(1);
            end else begin
                viol_count_d = viol_count_q;
            end
            if (!first_bad_valid_q) begin
                first_bad_valid_d = 1'b1;
                first_bad_d       = in_data;
            end else begin
                first_bad_valid_d = first_bad_valid_q;
            end
        end else begin
            viol_count_d = viol_count_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q       <= 1'b0;
            out_data_q        <= {WIDTH{1'b0}};
            out_ok_q          <= 1'b0;
            viol_count_q      <= {CNT_W{1'b0}};
            first_bad_valid_q <= 1'b0;
            first_bad_q       <= {WIDTH{1'b0}};
        end else begin
            out_valid_q       <= out_valid_d;
            out_data_q        <= out_data_d;
            out_ok_q          <= out_ok_d;
            viol_count_q      <= viol_count_d;
            first_bad_valid_q <= first_bad_valid_d;
            first_bad_q       <= first_bad_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign out_ok          = out_ok_q;
    assign viol_count      = viol_count_q;
    assign first_bad_valid = first_bad_valid_q;
    assign first_bad       = first_bad_q;

endmodule

// File: tb/tb_value_range_checker.sv
// Bench for value_range_checker. It runs two instances on the same input stream:
//   dut_a : default range [-10:10] exclude [1:2), CNT_W=8
//   dut_b : (-inf:10) exclude [1:2), CNT_W=2
// The driver updates a reference model and queues the expected outputs. A
// separate monitor compares the DUT outputs whenever out_valid is high.
module tb_value_range_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;
    logic        clear;

    logic        in_ready_a, out_valid_a, out_ok_a, fbv_a;
    logic [15:0] out_data_a, fb_a;
    logic [7:0]  vc_a;
    logic        in_ready_b, out_valid_b, out_ok_b, fbv_b;
    logic [15:0] out_data_b, fb_b;
    logic [1:0]  vc_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    value_range_checker dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_ok(out_ok_a), .clear(clear),
        .viol_count(vc_a), .first_bad_valid(fbv_a), .first_bad(fb_a)
    );

    value_range_checker #(.HI_INCL(1'b0), .LO_INF(1'b1), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_ok(out_ok_b), .clear(clear),
        .viol_count(vc_b), .first_bad_valid(fbv_b), .first_bad(fb_b)
    );

    typedef struct {
        int data;
        bit ok_a;
        bit ok_b;
    } item_t;

    item_t q[$];

    // Reference model state
    bit m_valid;
    int m_cnt[2];
    bit m_fbv[2];
    int m_fb[2];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Each allowed interval is rewritten as a closed integer interval. The
    // exclusion [1:2) then contains the single integer 1.
    function automatic bit ref_ok(input int x, input int cfg);
        int lo_min;
        int hi_max;
        if (cfg == 0) begin
            lo_min = -10;
            hi_max = 10;
        end else begin
            lo_min = -32768;
            hi_max = 10 - 1;
        end
        return (x >= lo_min) && (x <= hi_max) && !(x >= 1 && x <= 2 - 1);
    endfunction

    function automatic int cnt_max(input int cfg);
        return (cfg == 0) ? 255 : 3;
    endfunction

    task automatic check_status();
        chk("viol_count_a", int'(vc_a), m_cnt[0]);
        chk("viol_count_b", int'(vc_b), m_cnt[1]);
        chk("first_bad_valid_a", int'(fbv_a), int'(m_fbv[0]));
        chk("first_bad_valid_b", int'(fbv_b), int'(m_fbv[1]));
        if (m_fbv[0]) chk("first_bad_a", int'($signed(fb_a)), m_fb[0]);
        if (m_fbv[1]) chk("first_bad_b", int'($signed(fb_b)), m_fb[1]);
    endtask

    // One clock cycle of stimulus. Inputs are applied #1 after the rising edge,
    // and checks and the model update run on the falling edge.
    task automatic step(input bit v, input int d, input bit ordy, input bit clr);
        bit   exp_rdy;
        bit   acc;
        int   x;
        bit   okv[2];
        item_t it;
        in_valid  = v;
        in_data   = d[15:0];
        out_ready = ordy;
        clear     = clr;
        @(negedge clk);
        check_status();
        exp_rdy = !m_valid || ordy;
        chk("in_ready_a", int'(in_ready_a), int'(exp_rdy));
        chk("in_ready_b", int'(in_ready_b), int'(exp_rdy));
        acc = v && exp_rdy;
        x = int'($signed(in_data));
        okv[0] = ref_ok(x, 0);
        okv[1] = ref_ok(x, 1);
        if (acc) begin
            it.data = x;
            it.ok_a = okv[0];
            it.ok_b = okv[1];
            q.push_back(it);
        end
        if (acc) m_valid = 1'b1;
        else if (ordy) m_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bit viol;
            viol = acc && !okv[k];
            if (clr) begin
                m_cnt[k] = viol ? 1 : 0;
                m_fbv[k] = viol;
                if (viol) m_fb[k] = x;
            end else if (viol) begin
                if (m_cnt[k] < cnt_max(k)) m_cnt[k] = m_cnt[k] + 1;
                if (!m_fbv[k]) begin
                    m_fbv[k] = 1'b1;
                    m_fb[k]  = x;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_zero();
        m_valid = 1'b0;
        q.delete();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0;
            m_fbv[k] = 1'b0;
            m_fb[k]  = 0;
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        clear    = 1'b0;
        @(negedge clk);
        check_status();
        model_zero();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares the presented output with the oldest expected item and
    // retires that item on the output handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("out_valid_match", int'(out_valid_b), int'(out_valid_a));
            if (out_valid_a) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_unexpected: got data %0d with no expected item",
                             int'($signed(out_data_a)));
                end else begin
                    chk("out_data_a", int'($signed(out_data_a)), q[0].data);
                    chk("out_data_b", int'($signed(out_data_b)), q[0].data);
                    chk("out_ok_a", int'(out_ok_a), int'(q[0].ok_a));
                    chk("out_ok_b", int'(out_ok_b), int'(q[0].ok_b));
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dir_stream[7];
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'd0;
        out_ready = 1'b1;
        clear     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_zero();

        // Reset state
        chk("rst_out_valid", int'(out_valid_a), 0);
        chk("rst_out_data", int'(out_data_a), 0);
        chk("rst_out_ok", int'(out_ok_a), 0);
        chk("rst_first_bad", int'(fb_a), 0);
        step(1'b0, 0, 1'b1, 1'b0);

        // Directed stream with the default range
        dir_stream = '{-10, 10, 0, 1, 2, -11, 11};
        foreach (dir_stream[i]) step(1'b1, dir_stream[i], 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        chk("stream_viol_count", int'(vc_a), 3);
        chk("stream_first_bad", int'($signed(fb_a)), 1);

        // Bound types on dut_b: the upper bound 10 is open, the lower bound is -inf
        step(1'b1, 10, 1'b1, 1'b0);
        step(1'b1, 9, 1'b1, 1'b0);
        step(1'b1, -32768, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);

        // Backpressure
        step(1'b1, 5, 1'b0, 1'b0);
        repeat (3) step(1'b1, 7, 1'b0, 1'b0);
        chk("bp_hold_data", int'($signed(out_data_a)), 5);
        chk("bp_in_ready", int'(in_ready_a), 0);
        step(1'b1, 7, 1'b1, 1'b0);
        chk("bp_next_data", int'($signed(out_data_a)), 7);
        step(1'b0, 0, 1'b1, 1'b0);
        chk("bp_queue_empty", q.size(), 0);

        // Saturation on the 2-bit counter, then clear
        repeat (6) step(1'b1, 20, 1'b1, 1'b0);
        chk("sat_viol_count_b", int'(vc_b), 3);
        step(1'b0, 0, 1'b1, 1'b1);
        chk("clear_viol_count_b", int'(vc_b), 0);
        chk("clear_viol_count_a", int'(vc_a), 0);
        chk("clear_fbv_a", int'(fbv_a), 0);

        // Clear in the same cycle as an accepted violating sample
        step(1'b1, -11, 1'b1, 1'b0);
        repeat (3) step(1'b1, 20, 1'b1, 1'b0);
        chk("pre_clear_count_a", int'(vc_a), 4);
        chk("pre_clear_first_a", int'($signed(fb_a)), -11);
        step(1'b1, 1, 1'b1, 1'b1);
        chk("simul_count_a", int'(vc_a), 1);
        chk("simul_first_a", int'($signed(fb_a)), 1);
        chk("simul_fbv_a", int'(fbv_a), 1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int d;
            if ($urandom_range(0, 3) != 0) d = int'($urandom_range(0, 60)) - 30;
            else d = int'($signed(16'($urandom)));
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0);
        end
        repeat (2) step(1'b0, 0, 1'b1, 1'b0);
        chk("rand_queue_empty", q.size(), 0);

        // Reset while a sample is held under backpressure
        step(1'b1, 42, 1'b0, 1'b0);
        chk("pre_rst_out_valid", int'(out_valid_a), 1);
        do_reset();
        chk("mid_rst_out_valid", int'(out_valid_a), 0);
        chk("mid_rst_viol_count", int'(vc_a), 0);
        chk("mid_rst_fbv", int'(fbv_a), 0);
        chk("mid_rst_in_ready", int'(in_ready_a), 1);
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b1, -3, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        chk("final_queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/value_range_checker.md
Name: value_range_checker

Overview:
- Streaming range monitor for signed fixed-point samples, the runtime counterpart of the parameter value-range constraint `from [lo:hi] exclude [a:b)`.
- Sits between a sample producer and its consumer.
- Registers each accepted sample with a pass/fail flag.
- Keeps a saturating violation count and a sticky capture of the first offending sample for the testbench/status side.

Parameters:
- WIDTH, 16, sample width, two's-complement signed
- LO, -10, lower bound of the allowed range
- HI, 10, upper bound of the allowed range
- LO_INCL, 1, 1 = closed at LO (`[`), 0 = open (`(`)
- HI_INCL, 1, 1 = closed at HI (`]`), 0 = open (`)`)
- LO_INF, 0, 1 = lower bound is -inf; LO and LO_INCL are ignored
- HI_INF, 0, 1 = upper bound is +inf; HI and HI_INCL are ignored
- EXCL_EN, 1, enables the exclusion window
- EXCL_LO, 1, exclusion window lower bound, always inclusive
- EXCL_HI, 2, exclusion window upper bound, always exclusive
- CNT_W, 8, violation counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- in_valid  in  1  sample offered
- in_ready  out  1  block can accept
- in_data  in  WIDTH  signed sample
- out_valid  out  1  registered sample available
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  registered copy of the accepted sample
- out_ok  out  1  1 = sample inside range and outside exclusion window
- clear  in  1  single-cycle pulse; clears count and sticky capture
- viol_count  out  CNT_W  saturating count of rejected samples
- first_bad_valid  out  1  sticky; a violation has been captured
- first_bad  out  WIDTH  first violating sample since reset/clear

Behaviour:
- Reset (rst_n=0 at a clk edge) forces all state to zero: out_valid, out_data, out_ok, viol_count, first_bad_valid, first_bad.
  - Reset mid-transfer discards the held sample; no partial state survives.
- in_ready = !out_valid || out_ready. This is combinational, a single-entry pipeline register with no bubble on a continuous stream.
- Accept = in_valid && in_ready. On accept, the next edge loads out_data = in_data and out_ok = ok(in_data), and sets out_valid = 1. Latency is 1 cycle.
- If out_valid && out_ready with no accept, out_valid clears next edge; out_data and out_ok hold their last values.
- While out_valid && !out_ready, out_data and out_ok are stable.
- ok(x) = lo_pass && hi_pass && !excl_hit, all comparisons signed at WIDTH bits:
  - lo_pass = LO_INF ? 1 : (LO_INCL ? x >= LO : x > LO)
  - hi_pass = HI_INF ? 1 : (HI_INCL ? x <= HI : x < HI)
  - excl_hit = EXCL_EN && x >= EXCL_LO && x < EXCL_HI
- The ok computation is combinational on in_data, so there is a single register stage.
- Violation bookkeeping happens on accepted samples only (handshake-qualified, never on the output side):
  - viol_count += 1 per accepted violating sample, saturating at 2^CNT_W-1; it never wraps.
  - If first_bad_valid = 0, first_bad is loaded with the sample and first_bad_valid is set. Later violations do not overwrite it.
- clear: viol_count goes to 0 and first_bad_valid to 0.
  - If the same cycle has an accepted violating sample: viol_count = 1, first_bad = that sample, first_bad_valid = 1.
  - clear does not affect the data path.
- Degenerate configurations are legal:
  - LO > HI rejects every sample.
  - EXCL_LO >= EXCL_HI means the exclusion window is empty.
- Elaboration-time check: a $error fires if LO, HI, EXCL_LO or EXCL_HI is not representable in WIDTH signed bits.
- No state machine beyond the out_valid flag. Counter and capture form an independent control path.

Decomposition:
- Package value_range_pkg holds:
  - the range-descriptor struct (lo, hi, lo_incl, hi_incl, lo_inf, hi_inf, excl_en, excl_lo, excl_hi)
  - the function in_range(sample, desc), shared with bench scoreboards
- Sub-module range_compare: purely combinational ok(x) evaluator, parameterised by the same set, instantiated once. The top holds the pipeline register and the bookkeeping.

Test Plan:
- Defaults, stream -10, 10, 0, 1, 2, -11, 11 with out_ready=1:
  - out_ok = 1, 1, 1, 0, 1, 0, 0, one cycle after each accept
  - viol_count = 3; first_bad = 1
- Bound types, HI_INCL=0 and LO_INF=1:
  - 10 gives ok=0, 9 gives ok=1, -32768 gives ok=1
- Backpressure: out_ready=0 with 5 accepted, then offer 7:
  - in_ready=0; out_data stays 5 until out_ready=1
  - 7 appears the cycle after it is accepted; no sample lost or duplicated
- Saturation: CNT_W=2, six violating samples (e.g. 20) gives viol_count = 3; a clear pulse gives 0.
- Simultaneous clear with accept of 1.5-excluded value 1, when prior count = 4 and first_bad = -11:
  - viol_count = 1, first_bad = 1, first_bad_valid = 1
- Reset while out_valid=1 with out_ready=0:
  - next cycle out_valid = 0, viol_count = 0, first_bad_valid = 0, in_ready = 1
